// File: rtl/ddr_bram_responder.sv
// Block-RAM backed responder for the DDR initiator interface: masked burst writes,
// fixed-latency burst reads, one read outstanding at a time.
module ddr_bram_responder #(
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [7:0]  burst_count,
   input  logic [7:0]  mask,
   input  logic [63:0] din,
   output logic        wait_req,
   output logic        valid,
   output logic [63:0] dout
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ_BURST} state_t;
   typedef logic [ADDR_WIDTH-1:0] word_t;

   localparam word_t      WORD_ONE  = word_t'(1);
   localparam logic [3:0] WAIT_INIT = 4'(READ_LATENCY - 1);

   state_t      state_q, state_d;
   word_t       addr_q, addr_d;
   logic [7:0]  beats_q, beats_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        wait_req_q, wait_req_d;
   logic        valid_q, valid_d;
   logic [63:0] dout_q, dout_d;

   logic [63:0] mem [DEPTH];
   logic [63:0] ram_q;
   logic        we;
   word_t       waddr;
   word_t       word_in;
   logic [7:0]  beats_init;
   logic        unused_addr;

   assign word_in     = addr[ADDR_WIDTH+2:3];
   assign beats_init  = (burst_count == 8'd0) ? 8'd0 : burst_count - 8'd1;
   assign unused_addr = &{1'b0, addr[31:ADDR_WIDTH+3], addr[2:0]};

   // beats_q counts beats still to transfer after the current one.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d    = state_q;
      addr_d     = addr_q;
      beats_d    = beats_q;
      wait_cnt_d = wait_cnt_q;
      wait_req_d = wait_req_q;
      valid_d    = valid_q;
      dout_d     = dout_q;
      we         = 1'b0;
      waddr      = addr_q;

      unique case (state_q)
         IDLE: begin
            wait_req_d = 1'b0;
            if (wr && !wait_req_q) begin
               we      = 1'b1;
               waddr   = word_in;
               addr_d  = word_in + WORD_ONE;
               beats_d = beats_init;
               if (beats_init != 8'd0) state_d = WRITE;
            end else if (rd && !wait_req_q) begin
               addr_d     = word_in;
               beats_d    = beats_init;
               wait_cnt_d = WAIT_INIT;
               wait_req_d = 1'b1;
               state_d    = READ_WAIT;
            end
         end
         WRITE: begin
            wait_req_d = 1'b0;
            if (wr) begin
               we      = 1'b1;
               addr_d  = addr_q + WORD_ONE;
               beats_d = beats_q - 8'd1;
               if (beats_q == 8'd1) state_d = IDLE;
            end
         end
         READ_WAIT: begin
            if (wait_cnt_q == 4'd0) begin
               valid_d = 1'b1;
               dout_d  = ram_q;
               addr_d  = addr_q + WORD_ONE;
               state_d = READ_BURST;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         READ_BURST: begin
            if (beats_q == 8'd0) begin
               valid_d    = 1'b0;
               wait_req_d = 1'b0;
               state_d    = IDLE;
            end else begin
               valid_d = 1'b1;
               dout_d  = ram_q;
               addr_d  = addr_q + WORD_ONE;
               beats_d = beats_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reading at the next-state address keeps ram_q equal to mem[addr_q] with a synchronous read port.
   always_ff @(posedge clock) begin
      // NOTE: the RAM array has no reset; contents survive reset_n and it maps onto block RAM.
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (mask[i]) mem[waddr][8*i +: 8] <= din[8*i +: 8];
         end
      end
      ram_q <= mem[addr_d];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q    <= IDLE;
         addr_q     <= '0;
         beats_q    <= '0;
         wait_cnt_q <= '0;
         wait_req_q <= 1'b1;
         valid_q    <= 1'b0;
         dout_q     <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         beats_q    <= beats_d;
         wait_cnt_q <= wait_cnt_d;
         wait_req_q <= wait_req_d;
         valid_q    <= valid_d;
         dout_q     <= dout_d;
      end
   end

   assign wait_req = wait_req_q;
   assign valid    = valid_q;
   assign dout     = dout_q;

endmodule
